// File: rtl/c64_mem_map.sv
// C64 memory map with the 6510 on-chip processor port ($0000/$0001).
// Optional cartridge ROML/ROMH decode is enabled by defining MEM_MAP_CART_EN.
`timescale 1ns/1ps
module c64_mem_map #(
  parameter int         WIDTH      = 8,
  parameter logic [7:0] DDR_RESET  = 8'h00,
  parameter logic [7:0] PORT_RESET = 8'h37
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      cpu_ab,
  input  logic [WIDTH-1:0] cpu_do,
  input  logic             cpu_we,
  output logic [WIDTH-1:0] cpu_di,
  output logic [15:0]      ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_we,
  input  logic [WIDTH-1:0] ram_rdata,
  input  logic [WIDTH-1:0] basic_rdata,
  input  logic [WIDTH-1:0] kernal_rdata,
  input  logic [WIDTH-1:0] char_rdata,
  output logic             io_sel,
  output logic             io_we,
  input  logic [WIDTH-1:0] io_rdata,
`ifdef MEM_MAP_CART_EN
  input  logic             exrom,
  input  logic             game,
  input  logic [WIDTH-1:0] cart_rdata,
  output logic             roml_sel,
`endif
  input  logic [2:0]       port_in,
  output logic [2:0]       bank_cfg
);

  typedef enum logic [2:0] {
    SRC_RAM    = 3'd0,
    SRC_BASIC  = 3'd1,
    SRC_KERNAL = 3'd2,
    SRC_CHAR   = 3'd3,
    SRC_IO     = 3'd4,
    SRC_PORT   = 3'd5,
    SRC_CART   = 3'd6
  } src_e;

  src_e       src_d, src_q;
  logic [7:0] ddr_d, ddr_q;
  logic [7:0] pdata_d, pdata_q;
  logic [7:0] port_d, port_q;
  logic [7:0] pins;
  logic       loram, hiram, charen;

  // Undriven (input) port bits float high; bits 5:3 come from the cassette lines.
  assign pins     = (pdata_q & ddr_q) | (~ddr_q & {2'b11, port_in, 3'b111});
  assign bank_cfg = reset ? 3'b111 : pins[2:0];
  assign loram    = bank_cfg[0];
  assign hiram    = bank_cfg[1];
  assign charen   = bank_cfg[2];

  assign ram_addr  = cpu_ab;
  assign ram_wdata = cpu_do;

  always_comb begin
    src_d = SRC_RAM;
    if (cpu_ab[15:1] == 15'd0) begin
      src_d = SRC_PORT;
    end else begin
      case (cpu_ab[15:12])
`ifdef MEM_MAP_CART_EN
        4'h8, 4'h9: if (!exrom && loram && hiram) src_d = SRC_CART;
        4'hA, 4'hB: begin
          if (!exrom && !game && hiram) src_d = SRC_CART;
          else if (loram && hiram)      src_d = SRC_BASIC;
        end
`else
        4'hA, 4'hB: if (loram && hiram) src_d = SRC_BASIC;
`endif
        4'hD:       if (loram || hiram) src_d = charen ? SRC_IO : SRC_CHAR;
        4'hE, 4'hF: if (hiram) src_d = SRC_KERNAL;
        default:    src_d = SRC_RAM;
      endcase
    end
  end

  // ROM regions write through to the RAM underneath; only the port and I/O block RAM writes.
  assign io_sel = (src_d == SRC_IO);
  assign io_we  = cpu_we & ~reset & io_sel;
  assign ram_we = cpu_we & ~reset & (src_d != SRC_PORT) & (src_d != SRC_IO);
`ifdef MEM_MAP_CART_EN
  assign roml_sel = (src_d == SRC_CART) && (cpu_ab[15:13] == 3'b100);
`endif

  always_comb begin
    ddr_d   = ddr_q;
    pdata_d = pdata_q;
    port_d  = port_q;
    if (src_d == SRC_PORT) begin
      port_d = cpu_ab[0] ? pins : ddr_q;
      if (cpu_we) begin
        if (cpu_ab[0]) pdata_d = cpu_do;
        else           ddr_d   = cpu_do;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ddr_q   <= DDR_RESET;
      pdata_q <= PORT_RESET;
      port_q  <= 8'h00;
      src_q   <= SRC_RAM;
    end else begin
      ddr_q   <= ddr_d;
      pdata_q <= pdata_d;
      port_q  <= port_d;
      src_q   <= src_d;
    end
  end

  always_comb begin
    cpu_di = ram_rdata;
    case (src_q)
      SRC_BASIC:  cpu_di = basic_rdata;
      SRC_KERNAL: cpu_di = kernal_rdata;
      SRC_CHAR:   cpu_di = char_rdata;
      SRC_IO:     cpu_di = io_rdata;
      SRC_PORT:   cpu_di = port_q;
`ifdef MEM_MAP_CART_EN
      SRC_CART:   cpu_di = cart_rdata;
`endif
      default:    cpu_di = ram_rdata;
    endcase
  end

endmodule
